// File: rtl/i2c_target_pkg.sv
// Shared types and constants for the I2C target byte receiver.
package i2c_target_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RECEIVE  = 2'd1,
    ACK_WAIT = 2'd2,
    ACK_HOLD = 2'd3
  } i2c_state_e;

  localparam int I2C_BYTE_BITS = 8;

  // Bus levels seen on SDA during the 9th clock.
  localparam logic I2C_ACK_LEVEL  = 1'b0;
  localparam logic I2C_NACK_LEVEL = 1'b1;

endpackage

// File: rtl/i2c_line_conditioner.sv
// Synchronizer, optional stability filter (I2C_RX_GLITCH_FILTER_EN) and edge strobes
// for one raw I2C bus line.
module i2c_line_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level,
  output logic rise,
  output logic fall
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be in 2..4");
  end
  if (FILTER_LEN < 2 || FILTER_LEN > 8) begin : g_bad_filter_len
    $error("FILTER_LEN must be in 2..8");
  end

  // Reset to 1 so an idle bus does not produce a phantom edge out of reset.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '1;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef I2C_RX_GLITCH_FILTER_EN
  logic       filt_q;
  logic [3:0] cnt_q;

  // Counts consecutive samples that disagree with the filtered level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else if (synced == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == 4'(FILTER_LEN - 1)) begin
      filt_q <= synced;
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign level = filt_q;
`else
  assign level = synced;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b1;
    else        prev_q <= level;
  end

  assign rise = level & ~prev_q;
  assign fall = ~level & prev_q;

endmodule

// File: rtl/i2c_target_rx_byte.sv
// I2C target byte receiver: START/STOP detection, MSB-first shift-in, ACK/NACK drive.
// Optional glitch filter on both lines via I2C_RX_GLITCH_FILTER_EN.
module i2c_target_rx_byte
  import i2c_target_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_pull_low,
  input  logic       ack_en,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       start_det,
  output logic       stop_det,
  output logic       busy,
  output i2c_state_e state
);

  // Handshake: rx_valid is a one-cycle strobe with no back-pressure; the consumer
  // must take rx_byte (held until the next byte) and present ack_en in that cycle.

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_line_conditioner #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl (
    .clk(clk), .rst_n(rst_n), .line_in(scl_in),
    .level(scl_lvl), .rise(scl_rise), .fall(scl_fall)
  );

  i2c_line_conditioner #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda (
    .clk(clk), .rst_n(rst_n), .line_in(sda_in),
    .level(sda_lvl), .rise(sda_rise), .fall(sda_fall)
  );

  i2c_state_e state_q;
  logic [2:0] bit_cnt;
  logic [7:0] shift_q;
  logic [7:0] shift_next;
  logic       ack_q;
  logic       ack_now;

  assign shift_next = {shift_q[6:0], sda_lvl};
  assign state      = state_q;
  // ack_en is owned by the consumer during the rx_valid cycle.
  assign ack_now    = rx_valid ? ack_en : ack_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bit_cnt      <= '0;
      shift_q      <= '0;
      ack_q        <= 1'b0;
      sda_pull_low <= 1'b0;
      rx_byte      <= 8'h00;
      rx_valid     <= 1'b0;
      start_det    <= 1'b0;
      stop_det     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
      if (sda_fall && scl_lvl) begin
        state_q      <= RECEIVE;
        sda_pull_low <= 1'b0;
        bit_cnt      <= '0;
        shift_q      <= '0;
        start_det    <= 1'b1;
        busy         <= 1'b1;
      end else if (sda_rise && scl_lvl) begin
        state_q      <= IDLE;
        sda_pull_low <= 1'b0;
        bit_cnt      <= '0;
        shift_q      <= '0;
        stop_det     <= 1'b1;
        busy         <= 1'b0;
      end else begin
        case (state_q)
          IDLE: ;
          RECEIVE: begin
            if (scl_rise) begin
              shift_q <= shift_next;
              if (bit_cnt == 3'(I2C_BYTE_BITS - 1)) begin
                rx_byte  <= shift_next;
                rx_valid <= 1'b1;
                ack_q    <= ack_en;
                state_q  <= ACK_WAIT;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          ACK_WAIT: begin
            if (rx_valid) ack_q <= ack_en;
            if (scl_fall) begin
              sda_pull_low <= ((ack_now ? I2C_ACK_LEVEL : I2C_NACK_LEVEL) == 1'b0);
              state_q      <= ACK_HOLD;
            end
          end
          ACK_HOLD: begin
            if (scl_fall) begin
              sda_pull_low <= 1'b0;
              bit_cnt      <= '0;
              shift_q      <= '0;
              state_q      <= RECEIVE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_rx_byte.sv
// Self-checking bench: an I2C master model drives a wired-AND bus into the receiver.
module tb_i2c_target_rx_byte;
  import i2c_target_pkg::*;

  localparam int Q = 10;  // quarter SCL period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_drv = 1'b1;
  logic       sda_drv = 1'b1;
  logic       ack_en = 1'b0;
  logic       sda_bus;
  logic       sda_pull_low;
  logic [7:0] rx_byte;
  logic       rx_valid, start_det, stop_det, busy;
  i2c_state_e state;

  always #5 clk = ~clk;

  assign sda_bus = sda_drv & ~sda_pull_low;

  i2c_target_rx_byte dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_drv), .sda_in(sda_bus),
    .sda_pull_low(sda_pull_low), .ack_en(ack_en), .rx_byte(rx_byte),
    .rx_valid(rx_valid), .start_det(start_det), .stop_det(stop_det),
    .busy(busy), .state(state)
  );

  int checks = 0;
  int fails  = 0;
  int valid_cnt = 0, start_cnt = 0, stop_cnt = 0, pull_cycles = 0;
  int exp_start = 0, exp_stop = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       ack;
    logic       exp_pull;
  } vec_t;
  vec_t vecs[4];

  // Pulse monitor
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid)     valid_cnt++;
      if (start_det)    start_cnt++;
      if (stop_det)     stop_cnt++;
      if (sda_pull_low) pull_cycles++;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_start();
    if (scl_drv == 1'b0) begin
      sda_drv = 1'b1;
      wait_clks(Q);
      scl_drv = 1'b1;
    end
    wait_clks(Q);
    sda_drv = 1'b0;
    wait_clks(2 * Q);
    scl_drv = 1'b0;
    wait_clks(Q);
    exp_start++;
  endtask

  task automatic bus_stop();
    sda_drv = 1'b0;
    wait_clks(Q);
    scl_drv = 1'b1;
    wait_clks(2 * Q);
    sda_drv = 1'b1;
    wait_clks(2 * Q);
    exp_stop++;
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b;
    wait_clks(Q);
    scl_drv = 1'b1;
    wait_clks(2 * Q);
    scl_drv = 1'b0;
    wait_clks(Q);
  endtask

  // Full 9-clock frame; the model expects the byte back and the ACK drive to follow ack.
  task automatic send_byte(input logic [7:0] d, input logic a, input logic exp_pull,
                           input logic spike);
    int   v0, p0;
    logic p_low, p_high, p_after;
    v0 = valid_cnt;
    p0 = pull_cycles;
    ack_en = a;
    for (int i = 7; i >= 0; i--) begin
      if (spike && i == 4) begin
        sda_drv = d[i];
        wait_clks(3);
        scl_drv = 1'b1;
        wait_clks(2);
        scl_drv = 1'b0;
        wait_clks(3);
      end
      send_bit(d[i]);
    end
    exp_q.push_back(d);
    sda_drv = 1'b1;
    wait_clks(Q);
    p_low = sda_pull_low;
    scl_drv = 1'b1;
    wait_clks(Q);
    p_high = sda_pull_low;
    wait_clks(Q);
    scl_drv = 1'b0;
    wait_clks(Q);
    p_after = sda_pull_low;
    check("rx_valid_count", valid_cnt - v0, 1);
    check("rx_byte", rx_byte, exp_q.pop_front());
    check("pull_before_9th_rise", p_low, exp_pull);
    check("pull_during_9th_high", p_high, exp_pull);
    check("pull_after_9th_fall", p_after, 0);
    if (!exp_pull) check("nack_never_pulled", pull_cycles - p0, 0);
  endtask

  initial begin
    vecs[0] = '{data: 8'hA5, ack: 1'b1, exp_pull: 1'b1};
    vecs[1] = '{data: 8'h3C, ack: 1'b0, exp_pull: 1'b0};
    vecs[2] = '{data: 8'h00, ack: 1'b1, exp_pull: 1'b1};
    vecs[3] = '{data: 8'hFF, ack: 1'b0, exp_pull: 1'b0};

    // Reset state
    wait_clks(5);
    check("reset_sda_pull_low", sda_pull_low, 0);
    check("reset_rx_byte", rx_byte, 8'h00);
    check("reset_rx_valid", rx_valid, 0);
    check("reset_start_det", start_det, 0);
    check("reset_stop_det", stop_det, 0);
    check("reset_busy", busy, 0);
    check("reset_state", state, IDLE);
    rst_n = 1'b1;
    wait_clks(10);

    // Table-driven bytes in one transaction
    bus_start();
    check("busy_after_start", busy, 1);
    check("state_after_start", state, RECEIVE);
    for (int i = 0; i < 4; i++) send_byte(vecs[i].data, vecs[i].ack, vecs[i].exp_pull, 1'b0);
    bus_stop();
    check("stop_count_table", stop_cnt, exp_stop);
    check("busy_after_stop", busy, 0);

    // Random bytes and ACK choices
    bus_start();
    for (int i = 0; i < 16; i++) begin
      logic [7:0] d;
      logic       a;
      d = 8'($urandom_range(0, 255));
      a = 1'($urandom_range(0, 1));
      send_byte(d, a, a, 1'b0);
    end
    bus_stop();

    // Partial byte aborted by STOP
    begin
      int v0;
      v0 = valid_cnt;
      bus_start();
      for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
      bus_stop();
      check("partial_no_rx_valid", valid_cnt - v0, 0);
      check("partial_stop_count", stop_cnt, exp_stop);
      check("partial_busy", busy, 0);
      check("partial_state", state, IDLE);
    end

    // Repeated START between two bytes
    begin
      int s0;
      s0 = start_cnt;
      bus_start();
      send_byte(8'h01, 1'b1, 1'b1, 1'b0);
      bus_start();
      check("busy_after_rep_start", busy, 1);
      send_byte(8'hFE, 1'b1, 1'b1, 1'b0);
      check("rep_start_pulses", start_cnt - s0, 2);
      check("busy_before_stop", busy, 1);
      bus_stop();
      check("start_count_total", start_cnt, exp_start);
    end

`ifdef I2C_RX_GLITCH_FILTER_EN
    // Short SCL spike mid-byte must not add a bit
    bus_start();
    send_byte(8'h55, 1'b1, 1'b1, 1'b1);
    bus_stop();
`endif

    // Reset while holding the ACK
    bus_start();
    ack_en = 1'b1;
    for (int i = 7; i >= 0; i--) send_bit(((8'h5A >> i) & 8'h01) != 8'h00);
    sda_drv = 1'b1;
    wait_clks(Q);
    scl_drv = 1'b1;
    wait_clks(Q);
    check("ack_hold_state", state, ACK_HOLD);
    check("ack_hold_pull", sda_pull_low, 1);
    check("ack_hold_rx_byte", rx_byte, 8'h5A);
    rst_n = 1'b0;
    #1;
    check("rst_pull_released", sda_pull_low, 0);
    check("rst_rx_byte", rx_byte, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_start_det", start_det, 0);
    check("rst_stop_det", stop_det, 0);
    check("rst_state", state, IDLE);
    wait_clks(5);
    rst_n = 1'b1;
    wait_clks(10);
    check("post_rst_state", state, IDLE);
    check("post_rst_stop_count", stop_cnt, exp_stop);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/i2c_target_rx_byte.md
# i2c_target_rx_byte

I2C target-side byte receiver: the far end of the master byte transmitter. It oversamples SCL/SDA on the system clock, detects START/STOP, shifts in 8 data bits MSB-first on SCL rising edges, and answers the 9th clock with ACK or NACK by pulling SDA low through an open-drain enable. It sits between the I2C pads and a target-side register or address-match layer, which sees one `rx_valid` pulse per byte.

## Interface
- `SYNC_STAGES`, 2: synchronizer flops per bus line; legal 2..4.
- `FILTER_LEN`, 3: glitch-filter length in clk cycles; used only with `I2C_RX_GLITCH_FILTER_EN`; legal 2..8.
- `clk`  in  1  system clock, at least 20× SCL.
- `rst_n`  in  1  asynchronous, active-low reset.
- `scl_in`  in  1  raw SCL pad input, asynchronous.
- `sda_in`  in  1  raw SDA pad input, asynchronous.
- `sda_pull_low`  out  1  1 = drive SDA low; 0 = release. Open drain only.
- `ack_en`  in  1  sampled when the byte completes: 1 = ACK, 0 = NACK.
- `rx_byte`  out  8  last received byte; valid while `rx_valid`; holds until the next byte.
- `rx_valid`  out  1  one-cycle pulse when 8 bits are complete.
- `start_det`  out  1  one-cycle pulse on START or repeated START.
- `stop_det`  out  1  one-cycle pulse on STOP.
- `busy`  out  1  1 from START until STOP.

## Operation
- Inputs pass through `SYNC_STAGES` flops, then one flop of history for edge detection: `scl_rise`, `scl_fall`, `sda_rise`, `sda_fall`.
- START means `sda_fall` while synced SCL = 1. STOP means `sda_rise` while synced SCL = 1. Both override every state.
- States:
  - IDLE: wait for START. Any data traffic is ignored.
  - RECEIVE: on `scl_rise`, shift in SDA and increment `bit_cnt` (0..7). On the 8th rise, load `rx_byte`, pulse `rx_valid`, latch `ack_en` into `ack_q`, and go to ACK_WAIT.
  - ACK_WAIT: on `scl_fall`, set `sda_pull_low = ack_q` and go to ACK_HOLD.
  - ACK_HOLD: hold the SDA drive through the 9th SCL high. On the next `scl_fall`, release SDA, clear `bit_cnt`, and go to RECEIVE.
- A START from any state: release SDA, clear `bit_cnt` and the shift register, pulse `start_det`, set `busy`, and go to RECEIVE.
- A STOP from any state: release SDA, pulse `stop_det`, clear `busy`, and go to IDLE. A partial byte is discarded with no `rx_valid`.
- START and a `scl_rise` in the same cycle: START wins and the bit is not shifted.
- The block never detects START/STOP caused by its own ACK, because SDA only changes while SCL is low.
- Reset values: `sda_pull_low`=0, `rx_byte`=8'h00, `rx_valid`=0, `start_det`=0, `stop_det`=0, `busy`=0, state IDLE, `bit_cnt`=0.
- Asserting `rst_n` low mid-byte releases SDA at once (asynchronously).

## Timing
- Latency from a pad edge to the internal edge strobe is `SYNC_STAGES`+1 clk cycles (+`FILTER_LEN` when filtering is enabled).
- `rx_valid` is a registered pulse, high in the cycle after the 8th `scl_rise` strobe.
- `sda_pull_low` changes in the cycle after the `scl_fall` strobe.
  - SDA setup before the 9th SCL rise is therefore roughly half an SCL period minus the sync latency.
- `start_det`/`stop_det` pulse in the cycle after the detecting strobe.
- `ack_en` must be stable in the `rx_valid` cycle; later changes have no effect on the current byte.
- No clock stretching: the block never drives SCL.

## Configuration
- `I2C_RX_GLITCH_FILTER_EN` defined: each synced line passes a majority/stability filter. The filtered value changes only after `FILTER_LEN` consecutive equal samples, which suppresses spikes shorter than `FILTER_LEN` clk cycles.
- Undefined: the synced lines feed edge detection directly, and `FILTER_LEN` is ignored.

## Structure
- Shared package `i2c_target_pkg`:
  - state enum `{IDLE, RECEIVE, ACK_WAIT, ACK_HOLD}`
  - `I2C_BYTE_BITS = 8`
  - ACK/NACK level constants
- Sub-module `i2c_line_conditioner`, instantiated once per line. It contains the synchronizer, the optional filter and the rise/fall strobes, and outputs level, rise and fall.

## Test plan
- START, byte 8'hA5 MSB-first, `ack_en`=1 → one `rx_valid` with `rx_byte`=8'hA5; `sda_pull_low`=1 from the 8th SCL fall to the 9th SCL fall.
- Byte 8'h3C with `ack_en`=0 → `rx_byte`=8'h3C and `sda_pull_low` stays 0 throughout (NACK).
- START, 4 bits, STOP → `stop_det` pulse, no `rx_valid`, `busy`=0, state IDLE.
- Byte 8'h01, then repeated START, then byte 8'hFE → `start_det` pulses twice, `rx_valid` pulses twice with 8'h01 then 8'hFE, and `busy` stays 1.
- Reset during ACK_HOLD → `sda_pull_low` falls to 0 immediately and every output returns to its reset value.
- With `I2C_RX_GLITCH_FILTER_EN` and `FILTER_LEN`=3: a 2-clk SCL spike mid-byte causes no extra shifted bit, and the byte 8'h55 is received intact.
